// File: rtl/commit_bus_arbiter_pkg.sv
// Shared definitions for the commit bus arbiter: default geometry of the
// arbiter and a population-count helper used by the optional statistics.
package commit_bus_arbiter_pkg;

  localparam int COMMIT_PACKET_SIZE = 32;
  localparam int COMMIT_ARB_NUM_RS  = 8;
  localparam int COMMIT_ARB_IDX_W   = 4;
  localparam int COMMIT_ARB_MAX_RS  = 16;

  function automatic logic [4:0] count_ones(input logic [COMMIT_ARB_MAX_RS-1:0] bits);
    logic [4:0] total;
    total = '0;
    for (int i = 0; i < COMMIT_ARB_MAX_RS; i++) begin
      total = total + {4'd0, bits[i]};
    end
    return total;
  endfunction

endpackage

// File: rtl/commit_bus_arbiter_picker.sv
// Combinational round-robin picker. The eligible vector is laid out twice:
// the low copy keeps only stations at or above the pointer, the high copy
// keeps all stations, so the lowest set bit of the doubled vector is the
// first eligible station searching upward from the pointer with wrap.
module rr_priority_picker
  import commit_bus_arbiter_pkg::*;
#(
  parameter int NUM_RS = COMMIT_ARB_NUM_RS,
  parameter int IDX_W  = COMMIT_ARB_IDX_W
) (
  input  logic [NUM_RS-1:0] eligible,
  input  logic [IDX_W-1:0]  pointer,
  output logic [NUM_RS-1:0] winner_onehot,
  output logic [IDX_W-1:0]  winner_idx,
  output logic              any_valid
);

  logic [NUM_RS-1:0]   upper_mask;
  logic [2*NUM_RS-1:0] doubled;
  int                  first_set;
  int                  sel;

  // Keep only stations whose index is at or above the round-robin pointer.
  always_comb begin
    upper_mask = '0;
    for (int i = 0; i < NUM_RS; i++) begin
      upper_mask[i] = (IDX_W'(i) >= pointer);
    end
  end

  assign doubled = {eligible, eligible & upper_mask};

  // Lowest set bit of the doubled vector, folded back into a station index.
  always_comb begin
    first_set = 0;
    for (int j = 2*NUM_RS-1; j >= 0; j--) begin
      if (doubled[j]) begin
        first_set = j;
      end
    end
    sel           = (first_set >= NUM_RS) ? (first_set - NUM_RS) : first_set;
    any_valid     = |eligible;
    winner_idx    = any_valid ? IDX_W'(sel) : '0;
    winner_onehot = any_valid ? (NUM_RS'(1) << sel) : '0;
  end

endmodule

// File: rtl/commit_bus_arbiter.sv
// Round-robin arbiter for the shared commit bus. A winning station receives
// a one-cycle grant pulse; on the following edge its packet is captured onto
// the commit bus with a valid strobe (two cycles from request to bus).
// Optional feature macro: COMMIT_ARB_STATS_EN adds commit and conflict counters.
module commit_bus_arbiter
  import commit_bus_arbiter_pkg::*;
#(
  parameter int NUM_RS = COMMIT_ARB_NUM_RS,
  parameter int PKT_W  = COMMIT_PACKET_SIZE,
  parameter int IDX_W  = COMMIT_ARB_IDX_W
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic [NUM_RS-1:0]       iCommitRequest,
  input  logic [NUM_RS*PKT_W-1:0] iCommitData,
  input  logic                    iCommitHold,
  output logic [NUM_RS-1:0]       oCommitGranted,
  output logic [PKT_W-1:0]        oCommitBus,
  output logic                    oCommitValid,
  output logic [IDX_W-1:0]        oCommitSrc
`ifdef COMMIT_ARB_STATS_EN
  ,
  output logic [31:0]             oCommitCount,
  output logic [31:0]             oConflictCount
`endif
);

  logic [NUM_RS-1:0] eligible;
  logic [NUM_RS-1:0] pick_onehot;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_valid;
  logic              issue_grant;
  logic [IDX_W-1:0]  rr_pointer;
  logic [IDX_W-1:0]  pointer_next;
  logic [IDX_W-1:0]  grant_idx;
  logic [PKT_W-1:0]  granted_packet;

  // The station granted last cycle still shows its request, so mask it out.
  assign eligible    = iCommitRequest & ~oCommitGranted;
  assign issue_grant = pick_valid & ~iCommitHold;

  rr_priority_picker #(
    .NUM_RS (NUM_RS),
    .IDX_W  (IDX_W)
  ) u_picker (
    .eligible      (eligible),
    .pointer       (rr_pointer),
    .winner_onehot (pick_onehot),
    .winner_idx    (pick_idx),
    .any_valid     (pick_valid)
  );

  // Pointer moves just past the winner, wrapping at the last station.
  always_comb begin
    pointer_next = rr_pointer;
    if (issue_grant) begin
      pointer_next = (pick_idx == IDX_W'(NUM_RS-1)) ? '0 : pick_idx + 1'b1;
    end
  end

  // Select the packet of the station currently holding the grant.
  always_comb begin
    granted_packet = '0;
    for (int i = 0; i < NUM_RS; i++) begin
      if (grant_idx == IDX_W'(i)) begin
        granted_packet = iCommitData[i*PKT_W +: PKT_W];
      end
    end
  end

  // Grant, pointer and commit-bus registers; reset cancels any grant in flight.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      oCommitGranted <= '0;
      grant_idx      <= '0;
      rr_pointer     <= '0;
      oCommitValid   <= 1'b0;
      oCommitBus     <= '0;
      oCommitSrc     <= '0;
    end else begin
      oCommitGranted <= issue_grant ? pick_onehot : '0;
      if (issue_grant) begin
        grant_idx <= pick_idx;
      end
      rr_pointer   <= pointer_next;
      oCommitValid <= |oCommitGranted;
      if (|oCommitGranted) begin
        oCommitBus <= granted_packet;
        oCommitSrc <= grant_idx;
      end
    end
  end

`ifdef COMMIT_ARB_STATS_EN
  logic contended;

  assign contended = (count_ones(COMMIT_ARB_MAX_RS'(eligible)) >= 5'd2) && !iCommitHold;

  // Running totals of delivered commits and contended arbitration cycles.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      oCommitCount   <= '0;
      oConflictCount <= '0;
    end else begin
      if (oCommitValid) begin
        oCommitCount <= oCommitCount + 32'd1;
      end
      if (contended) begin
        oConflictCount <= oConflictCount + 32'd1;
      end
    end
  end
`endif

endmodule
